// File: rtl/cva5_types.sv
// Shared CVA5 types for the AMO path: funct5 codes and the AMO ALU input bundle.
package cva5_types;

   typedef logic [4:0] amo_fn5_t;

   localparam amo_fn5_t AMO_ADD_FN5  = 5'b00000;
   localparam amo_fn5_t AMO_SWAP_FN5 = 5'b00001;
   localparam amo_fn5_t AMO_LR_FN5   = 5'b00010;
   localparam amo_fn5_t AMO_SC_FN5   = 5'b00011;
   localparam amo_fn5_t AMO_XOR_FN5  = 5'b00100;
   localparam amo_fn5_t AMO_OR_FN5   = 5'b01000;
   localparam amo_fn5_t AMO_AND_FN5  = 5'b01100;
   localparam amo_fn5_t AMO_MIN_FN5  = 5'b10000;
   localparam amo_fn5_t AMO_MAX_FN5  = 5'b10100;
   localparam amo_fn5_t AMO_MINU_FN5 = 5'b11000;
   localparam amo_fn5_t AMO_MAXU_FN5 = 5'b11100;

   typedef struct packed {
      amo_fn5_t    op;
      logic [31:0] rs1_load;
      logic [31:0] rs2;
   } amo_alu_inputs_t;

endpackage

// File: rtl/amo_sequencer_if.sv
// AMO request, data-memory port and writeback result bundle for amo_sequencer.
interface amo_sequencer_if #(
   parameter int ID_W = 3
);
   logic            amo_valid;
   logic            amo_ready;
   logic [4:0]      amo_op;
   logic [31:0]     amo_addr;
   logic [31:0]     amo_rs2;
   logic [ID_W-1:0] amo_id;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic            mem_rvalid;
   logic [31:0]     mem_rdata;

   logic            result_valid;
   logic            result_ack;
   logic [31:0]     result_data;
   logic [ID_W-1:0] result_id;

   modport master (
      output amo_valid, amo_op, amo_addr, amo_rs2, amo_id,
      input  amo_ready,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata,
      output mem_req_ready, mem_rvalid, mem_rdata,
      input  result_valid, result_data, result_id,
      output result_ack
   );

   modport slave (
      input  amo_valid, amo_op, amo_addr, amo_rs2, amo_id,
      output amo_ready,
      output mem_req_valid, mem_we, mem_addr, mem_wdata,
      input  mem_req_ready, mem_rvalid, mem_rdata,
      output result_valid, result_data, result_id,
      input  result_ack
   );
endinterface

// File: rtl/amo_alu.sv
// Combinational RV32A AMO ALU: new memory value from the loaded word and rs2.
module amo_alu
   import cva5_types::*;
(
   input  amo_alu_inputs_t alu_in,
   output logic [31:0]     result
);
   logic signed [31:0] load_s;
   logic signed [31:0] rs2_s;

   assign load_s = signed'(alu_in.rs1_load);
   assign rs2_s  = signed'(alu_in.rs2);

   // SWAP, LR, SC and every undefined funct5 write rs2 back unchanged
   always_comb begin
      result = alu_in.rs2;
      case (alu_in.op)
         AMO_ADD_FN5:  result = alu_in.rs1_load + alu_in.rs2;
         AMO_XOR_FN5:  result = alu_in.rs1_load ^ alu_in.rs2;
         AMO_OR_FN5:   result = alu_in.rs1_load | alu_in.rs2;
         AMO_AND_FN5:  result = alu_in.rs1_load & alu_in.rs2;
         AMO_MIN_FN5:  result = (load_s < rs2_s) ? alu_in.rs1_load : alu_in.rs2;
         AMO_MAX_FN5:  result = (load_s > rs2_s) ? alu_in.rs1_load : alu_in.rs2;
         AMO_MINU_FN5: result = (alu_in.rs1_load < alu_in.rs2) ? alu_in.rs1_load : alu_in.rs2;
         AMO_MAXU_FN5: result = (alu_in.rs1_load > alu_in.rs2) ? alu_in.rs1_load : alu_in.rs2;
         default:      result = alu_in.rs2;
      endcase
   end
endmodule

// File: rtl/amo_sequencer.sv
// Single-outstanding RV32A AMO sequencer: load, ALU, store, return old value.
// Define CVA5_AMO_LRSC_EN to build the LR/SC reservation; otherwise SC always fails.
module amo_sequencer
   import cva5_types::*;
#(
   parameter int ID_W = 3
) (
   input logic            clk,
   input logic            rst,
   amo_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, LD_REQ, LD_WAIT, ST_REQ, SC_CHK, DONE
   } state_t;

   state_t          state_q, state_d;
   amo_fn5_t        op_q, op_d;
   logic [29:0]     addr_q, addr_d;
   logic [31:0]     rs2_q, rs2_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     result_q, result_d;

   amo_alu_inputs_t alu_in;
   logic [31:0]     alu_result;
   logic [1:0]      unused_addr_lsb;

   assign unused_addr_lsb = bus.amo_addr[1:0];

   assign alu_in.op       = op_q;
   assign alu_in.rs1_load = bus.mem_rdata;
   assign alu_in.rs2      = rs2_q;

   amo_alu u_amo_alu (
      .alu_in (alu_in),
      .result (alu_result)
   );

`ifdef CVA5_AMO_LRSC_EN
   logic        resv_valid_q, resv_valid_d;
   logic [29:0] resv_addr_q, resv_addr_d;
   logic        resv_hit;

   assign resv_hit = resv_valid_q && (resv_addr_q == addr_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         resv_valid_q <= 1'b0;
         resv_addr_q  <= '0;
      end else begin
         resv_valid_q <= resv_valid_d;
         resv_addr_q  <= resv_addr_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      rs2_d    = rs2_q;
      id_d     = id_q;
      wdata_d  = wdata_q;
      result_d = result_q;
`ifdef CVA5_AMO_LRSC_EN
      resv_valid_d = resv_valid_q;
      resv_addr_d  = resv_addr_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.amo_valid) begin
               op_d    = bus.amo_op;
               addr_d  = bus.amo_addr[31:2];
               rs2_d   = bus.amo_rs2;
               id_d    = bus.amo_id;
               state_d = (bus.amo_op == AMO_SC_FN5) ? SC_CHK : LD_REQ;
            end
         end
         LD_REQ: begin
            if (bus.mem_req_ready) state_d = LD_WAIT;
         end
         LD_WAIT: begin
            // Registering the ALU output keeps mem_wdata steady across store stalls
            if (bus.mem_rvalid) begin
               result_d = bus.mem_rdata;
               wdata_d  = alu_result;
               if (op_q == AMO_LR_FN5) begin
                  state_d = DONE;
`ifdef CVA5_AMO_LRSC_EN
                  resv_valid_d = 1'b1;
                  resv_addr_d  = addr_q;
`endif
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus.mem_req_ready) begin
               state_d = DONE;
`ifdef CVA5_AMO_LRSC_EN
               if (resv_hit) resv_valid_d = 1'b0;
`endif
            end
         end
         SC_CHK: begin
`ifdef CVA5_AMO_LRSC_EN
            resv_valid_d = 1'b0;
            if (resv_hit) begin
               wdata_d  = rs2_q;
               result_d = 32'd0;
               state_d  = ST_REQ;
            end else begin
               result_d = 32'd1;
               state_d  = DONE;
            end
`else
            result_d = 32'd1;
            state_d  = DONE;
`endif
         end
         DONE: begin
            if (bus.result_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         rs2_q    <= '0;
         id_q     <= '0;
         wdata_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         rs2_q    <= rs2_d;
         id_q     <= id_d;
         wdata_q  <= wdata_d;
         result_q <= result_d;
      end
   end

   assign bus.amo_ready     = (state_q == IDLE);
   assign bus.mem_req_valid = (state_q == LD_REQ) || (state_q == ST_REQ);
   assign bus.mem_we        = (state_q == ST_REQ);
   assign bus.mem_addr      = {addr_q, 2'b00};
   assign bus.mem_wdata     = wdata_q;
   assign bus.result_valid  = (state_q == DONE);
   assign bus.result_data   = result_q;
   assign bus.result_id     = id_q;
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed plus randomized bench for amo_sequencer against a word-memory reference model.
module tb_amo_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   amo_sequencer_if #(.ID_W(3)) bus ();

   amo_sequencer #(.ID_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [logic [29:0]];
`ifdef CVA5_AMO_LRSC_EN
   bit          resv_v = 0;
   logic [29:0] resv_a = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a[31:2]) ? mem[a[31:2]] : {a[31:2], 2'b11};
   endfunction

   // Expected new memory word from the architectural AMO rules
   function automatic logic [31:0] amo_ref(input logic [4:0] op, input logic [31:0] m, input logic [31:0] r);
      logic [31:0] ms, rs;
      ms = m ^ 32'h8000_0000;
      rs = r ^ 32'h8000_0000;
      case (op)
         5'b00000: return m + r;
         5'b00100: return m ^ r;
         5'b01000: return m | r;
         5'b01100: return m & r;
         5'b10000: return (ms < rs) ? m : r;
         5'b10100: return (ms > rs) ? m : r;
         5'b11000: return (m < r) ? m : r;
         5'b11100: return (m > r) ? m : r;
         default:  return r;
      endcase
   endfunction

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
`ifdef CVA5_AMO_LRSC_EN
      resv_v = 0;
`endif
   endtask

   task automatic do_amo(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [2:0] id, input int ld_st, input int rd_dly,
                         input int st_st, input int ack_st);
      logic [31:0] waddr, mval, exp_wdata, exp_res;
      bit is_sc, is_lr, sc_ok, do_store;
      waddr = {addr[31:2], 2'b00};
      mval  = mem_rd(addr);
      is_sc = (op == 5'b00011);
      is_lr = (op == 5'b00010);
      sc_ok = 0;
`ifdef CVA5_AMO_LRSC_EN
      if (is_sc) sc_ok = resv_v && (resv_a == addr[31:2]);
`endif
      do_store  = (!is_sc && !is_lr) || sc_ok;
      exp_wdata = is_sc ? rs2 : amo_ref(op, mval, rs2);
      exp_res   = is_sc ? (sc_ok ? 32'd0 : 32'd1) : mval;

      chk("idle_ready", {31'd0, bus.amo_ready}, 32'd1);
      if (bus.amo_ready !== 1'b1) apply_reset();
      bus.amo_valid = 1'b1;
      bus.amo_op    = op;
      bus.amo_addr  = addr;
      bus.amo_rs2   = rs2;
      bus.amo_id    = id;
      @(negedge clk);
      bus.amo_valid = 1'b0;
      bus.amo_op    = 5'($urandom);
      bus.amo_addr  = $urandom;
      bus.amo_rs2   = $urandom;
      bus.amo_id    = 3'($urandom);

      if (is_sc) begin
         chk("sc_chk_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
         chk("sc_chk_busy", {31'd0, bus.amo_ready}, 32'd0);
         @(negedge clk);
      end else begin
         for (int i = 0; i <= ld_st; i++) begin
            chk("ld_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            chk("ld_req_we", {31'd0, bus.mem_we}, 32'd0);
            chk("ld_req_addr", bus.mem_addr, waddr);
            bus.mem_req_ready = (i == ld_st);
            @(negedge clk);
         end
         bus.mem_req_ready = 1'b0;
         for (int i = 0; i <= rd_dly; i++) begin
            chk("ld_wait_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
            bus.mem_rvalid = (i == rd_dly);
            bus.mem_rdata  = (i == rd_dly) ? mval : $urandom;
            @(negedge clk);
         end
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = $urandom;
`ifdef CVA5_AMO_LRSC_EN
         if (is_lr) begin
            resv_v = 1;
            resv_a = addr[31:2];
         end
`endif
      end

      if (do_store) begin
         for (int i = 0; i <= st_st; i++) begin
            chk("st_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            chk("st_req_we", {31'd0, bus.mem_we}, 32'd1);
            chk("st_req_addr", bus.mem_addr, waddr);
            chk("st_req_wdata", bus.mem_wdata, exp_wdata);
            bus.mem_req_ready = (i == st_st);
            @(negedge clk);
         end
         bus.mem_req_ready = 1'b0;
         mem[addr[31:2]] = exp_wdata;
`ifdef CVA5_AMO_LRSC_EN
         if (resv_v && resv_a == addr[31:2]) resv_v = 0;
`endif
      end
`ifdef CVA5_AMO_LRSC_EN
      if (is_sc) resv_v = 0;
`endif

      // Stray read data during DONE must not disturb the held result
      for (int i = 0; i <= ack_st; i++) begin
         chk("res_valid", {31'd0, bus.result_valid}, 32'd1);
         chk("res_data", bus.result_data, exp_res);
         chk("res_id", {29'd0, bus.result_id}, {29'd0, id});
         chk("done_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
         chk("done_busy", {31'd0, bus.amo_ready}, 32'd0);
         bus.result_ack = (i == ack_st);
         bus.mem_rvalid = (i != ack_st);
         bus.mem_rdata  = $urandom;
         @(negedge clk);
      end
      bus.result_ack = 1'b0;
      bus.mem_rvalid = 1'b0;
      chk("ready_after_ack", {31'd0, bus.amo_ready}, 32'd1);
      chk("res_dropped", {31'd0, bus.result_valid}, 32'd0);
   endtask

   logic [4:0]  ops [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
                             5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b00101, 5'b11111};
   logic [31:0] addrs [3] = '{32'h200, 32'h204, 32'h300};

   initial begin
      bus.amo_valid = 0; bus.amo_op = 0; bus.amo_addr = 0; bus.amo_rs2 = 0; bus.amo_id = 0;
      bus.mem_req_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.result_ack = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, bus.amo_ready}, 32'd1);
      chk("rst_req", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_res", {31'd0, bus.result_valid}, 32'd0);
      chk("rst_data", bus.result_data | bus.mem_wdata | bus.mem_addr, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      mem[32'h100 >> 2] = 32'd5;
      do_amo(5'b00000, 32'h100, 32'd3, 3'd1, 0, 0, 0, 0);
      mem[32'h140 >> 2] = 32'hFFFF_FFFF;
      do_amo(5'b10000, 32'h140, 32'd1, 3'd2, 0, 0, 0, 0);
      mem[32'h140 >> 2] = 32'hFFFF_FFFF;
      do_amo(5'b11000, 32'h142, 32'd1, 3'd3, 0, 0, 0, 0);
      mem[32'h180 >> 2] = 32'h1234_5678;
      do_amo(5'b00100, 32'h180, 32'h0F0F_0F0F, 3'd4, 3, 1, 3, 2);

      mem[32'h200 >> 2] = 32'd9;
      do_amo(5'b00010, 32'h200, 32'd0, 3'd5, 0, 0, 0, 0);
      do_amo(5'b00011, 32'h200, 32'd7, 3'd6, 0, 0, 0, 0);
      do_amo(5'b00011, 32'h200, 32'd8, 3'd7, 0, 0, 0, 1);
      do_amo(5'b00010, 32'h200, 32'd0, 3'd0, 0, 2, 0, 0);
      do_amo(5'b00001, 32'h201, 32'd11, 3'd1, 1, 0, 1, 0);
      do_amo(5'b00011, 32'h200, 32'd12, 3'd2, 0, 0, 0, 0);

      // Reset while waiting for load data
      mem[32'h240 >> 2] = 32'h55;
      bus.amo_valid = 1; bus.amo_op = 5'b00000; bus.amo_addr = 32'h240; bus.amo_rs2 = 1; bus.amo_id = 3'd3;
      @(negedge clk);
      bus.amo_valid = 0; bus.mem_req_ready = 1;
      @(negedge clk);
      bus.mem_req_ready = 0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
`ifdef CVA5_AMO_LRSC_EN
      resv_v = 0;
`endif
      chk("mid_rst_req", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("mid_rst_res", {31'd0, bus.result_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.amo_ready}, 32'd1);
      chk("mid_rst_data", bus.result_data | bus.mem_wdata | bus.mem_addr | {29'd0, bus.result_id}, 32'd0);
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_rvalid = 0;
      repeat (3) begin
         chk("late_rvalid_req", {31'd0, bus.mem_req_valid}, 32'd0);
         chk("late_rvalid_res", {31'd0, bus.result_valid}, 32'd0);
         @(negedge clk);
      end

      for (int n = 0; n < 60; n++) begin
         do_amo(ops[$urandom_range(12)], addrs[$urandom_range(2)] | 32'($urandom_range(3)),
                ($urandom_range(3) == 0) ? 32'h8000_0000 | $urandom : $urandom_range(100),
                3'($urandom), $urandom_range(3), $urandom_range(2),
                $urandom_range(3), $urandom_range(2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
